viterbi_decoder: RTL
====================

// Module: viterbi_decoder
// PURPOSE
//  Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7,5 octal).
//  Sits directly downstream of the convolutional encoder and the PRML channel.
//  Takes the serial coded stream (p0 then p1 per symbol), runs 4-state add-compare-select and
//  register-exchange survivor paths, and emits one decoded bit per symbol after TB_DEPTH symbols.
// PARAMETERS
//  TB_DEPTH  15  survivor history length in symbols (>=4); sets decode latency
//  PM_W      5   path-metric width, unsigned, saturating
//  ERR_W     16  err_cnt width (VDEC_ERRCNT_EN only)
// PORTS
//  clock     in   1      single clock, all logic on posedge
//  reset     in   1      synchronous, active-high
//  in_valid  in   1      in carries a coded bit this cycle
//  in        in   1      coded bit; first valid bit after reset is p0
//  out_valid out  1      one-cycle pulse, out holds a decoded bit
//  out       out  1      decoded data bit
//  err_cnt   out  ERR_W  channel-error estimate (VDEC_ERRCNT_EN only)
// BEHAVIOUR
//  - Reset: phase=0, sym_cnt=0, PM[0]=0, PM[1..3]=2^PM_W-1, histories=0, out=0, out_valid=0, err_cnt=0.
//  - Code: state s={s1,s0}={u[n-1],u[n-2]}. Input u gives p0=u^s1^s0 and p1=u^s0. Next state={u,s1}.
//  - Pair assembly: valid bit with phase=0 goes into r0; phase->1. Valid bit with phase=1 completes
//    symbol (r0,in); phase->0. Gaps in in_valid are allowed and do not alter phase.
//  - On the completing edge E: BM = Hamming(received pair, branch label), 0..2.
//    For state {u,a}, predecessors are {a,0} (dec=0) and {a,1} (dec=1).
//    Cand = PM+BM, saturating at 2^PM_W-1. Select the smaller; a tie picks dec=0.
//    Then normalize: subtract min of the 4 new metrics from all, so the min is 0.
//    New history = {predecessor history[TB_DEPTH-2:0], u}.
//  - Output: at E+1, out = history[TB_DEPTH-1] of the best state and out_valid=1.
//    Best state = lowest PM; a tie picks the lowest index.
//    Output is produced only when sym_cnt reached TB_DEPTH-1 before E (FILL state otherwise).
//    out holds its value between pulses.
//  - FSM: FILL (sym_cnt<TB_DEPTH-1; sym_cnt++ per symbol; no output) -> RUN.
//    RUN is one output per symbol and stays until reset. sym_cnt saturates.
//  - Latency: the bit for symbol k appears at E(k+TB_DEPTH-1)+1.
//  - Reset during operation discards a half pair and all state; the next valid bit is p0.
//  - No backpressure: the consumer must accept every out_valid pulse.
// CONFIGURATION
//  - Macro VDEC_ERRCNT_EN defined: err_cnt adds each symbol's normalization amount (min new metric
//    before subtract). This gives the Hamming distance of the ML path to the received stream.
//    err_cnt saturates at 2^ERR_W-1 and is cleared by reset.
//  - Macro undefined: the err_cnt port and its logic are absent. Decoded output is identical.
// STRUCTURE
//  - Package vit_pkg: NUM_STATES=4, GEN_P0=3'b111, GEN_P1=3'b101, typedef state_t (logic[1:0]).
//    Also branch_label(state_t s, logic u) returning {p0,p1}.
//  - Sub-module vit_acs: one add-compare-select (2 metrics + 2 BMs in -> metric + decision out).
//    Instantiated 4x. Pair assembly, normalization, history and FSM live in the top module.
// TESTING
//  - Reset, then 7 valid bits: no out_valid. Check reset values of out, out_valid, err_cnt and PM.
//  - TB_DEPTH=4, data 1011000 -> coded 11 10 00 01 01 11 00.
//    Out pulses 1,0,1,1 one cycle after symbols 3..6 complete; err_cnt=0.
//  - Default params, 40 random bits encoded with a zero tail, then one bit of symbol 2 flipped.
//    All 40 bits are decoded correctly; err_cnt=1.
//  - Same stream with in_valid low for 1-3 random cycles between bits.
//    Output bits and order are identical; one pulse per symbol.
//  - Assert reset after p0 of symbol 5, then send a new stream.
//    Decoding restarts from state 0, the half pair is dropped, and FILL repeats (no pulse for TB_DEPTH-1 symbols).
//  - All-ones input (coded 11 01 10 10 ...) for 200 symbols: metrics stay normalized and never saturate.
//    Output is all ones.

Source files
------------

// File: rtl/vit_pkg.sv
// Shared definitions for the K=3, rate-1/2 (7,5 octal) Viterbi decoder:
// trellis constants, state type, decoder phase enum and branch-label helper.
package vit_pkg;

    localparam int         NUM_STATES = 4;
    localparam logic [2:0] GEN_P0     = 3'b111;
    localparam logic [2:0] GEN_P1     = 3'b101;

    typedef logic [1:0] state_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Encoder output {p0,p1} when input u leaves state s={u[n-1],u[n-2]}.
    function automatic logic [1:0] branch_label(state_t s, logic u);
        logic [2:0] taps;
        taps = {u, s};
        return {^(taps & GEN_P0), ^(taps & GEN_P1)};
    endfunction

endpackage

// File: rtl/vit_acs.sv
// One add-compare-select cell: extends two predecessor metrics by their branch
// metrics (saturating) and keeps the smaller; ties resolve to predecessor 0.
module vit_acs #(
    parameter int PM_W = 5
) (
    input  logic [PM_W-1:0] pm_0,
    input  logic [PM_W-1:0] pm_1,
    input  logic [1:0]      bm_0,
    input  logic [1:0]      bm_1,
    output logic [PM_W-1:0] pm_out,
    output logic            dec
);

    localparam logic [PM_W-1:0] PM_MAX = '1;

    function automatic logic [PM_W-1:0] sat_add(logic [PM_W-1:0] a, logic [1:0] b);
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return s[PM_W] ? PM_MAX : s[PM_W-1:0];
    endfunction

    logic [PM_W-1:0] cand_0;
    logic [PM_W-1:0] cand_1;

    always_comb begin
        cand_0 = sat_add(pm_0, bm_0);
        cand_1 = sat_add(pm_1, bm_1);
        dec    = (cand_1 < cand_0);
        pm_out = dec ? cand_1 : cand_0;
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, rate-1/2 K=3 (7,5) code, register-exchange survivors.
// Define VDEC_ERRCNT_EN to add the err_cnt channel-error estimate output.
module viterbi_decoder
    import vit_pkg::*;
#(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 5
`ifdef VDEC_ERRCNT_EN
    ,
    parameter int ERR_W    = 16
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    input  logic in,
    output logic out_valid,
    output logic out
`ifdef VDEC_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] err_cnt
`endif
);

    localparam int              CNT_W     = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(TB_DEPTH - 1);
    localparam logic [PM_W-1:0]  PM_MAX    = '1;

    function automatic logic [1:0] hamming2(logic [1:0] x);
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    logic                phase_q, phase_d;
    logic                r0_q, r0_d;
    logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
    fsm_t                fsm_q, fsm_d;
    logic [PM_W-1:0]     pm_q [NUM_STATES];
    logic [PM_W-1:0]     pm_d [NUM_STATES];
    logic [TB_DEPTH-1:0] hist_q [NUM_STATES];
    logic [TB_DEPTH-1:0] hist_d [NUM_STATES];
    logic                emit_q, emit_d;
    logic                out_q, out_d;
    logic                out_valid_q, out_valid_d;

    logic [1:0]          rx_pair;
    logic [PM_W-1:0]     acs_pm [NUM_STATES];
    logic                acs_dec [NUM_STATES];
    logic [PM_W-1:0]     pm_min;
    state_t              best;
    logic [PM_W-1:0]     best_pm;

    assign rx_pair = {r0_q, in};

    // State {u,a} is reached from {a,0} or {a,1} by input bit u.
    for (genvar t = 0; t < NUM_STATES; t++) begin : g_acs
        localparam state_t PRED0 = state_t'((t % 2) * 2);
        localparam state_t PRED1 = state_t'((t % 2) * 2 + 1);
        localparam logic   U     = (t >= 2);
        vit_acs #(.PM_W(PM_W)) u_acs (
            .pm_0  (pm_q[PRED0]),
            .pm_1  (pm_q[PRED1]),
            .bm_0  (hamming2(branch_label(PRED0, U) ^ rx_pair)),
            .bm_1  (hamming2(branch_label(PRED1, U) ^ rx_pair)),
            .pm_out(acs_pm[t]),
            .dec   (acs_dec[t])
        );
    end

    always_comb begin
        pm_min = acs_pm[0];
        for (int t = 1; t < NUM_STATES; t++) begin
            if (acs_pm[t] < pm_min) pm_min = acs_pm[t];
        end
    end

    // Best state is picked from the metrics already normalized at the previous edge.
    always_comb begin
        best    = '0;
        best_pm = pm_q[0];
        for (int t = 1; t < NUM_STATES; t++) begin
            if (pm_q[t] < best_pm) begin
                best_pm = pm_q[t];
                best    = state_t'(t);
            end
        end
    end

    always_comb begin : p_next
        state_t tt;
        state_t pred;
        phase_d     = phase_q;
        r0_d        = r0_q;
        sym_cnt_d   = sym_cnt_q;
        fsm_d       = fsm_q;
        pm_d        = pm_q;
        hist_d      = hist_q;
        emit_d      = 1'b0;
        out_d       = out_q;
        out_valid_d = 1'b0;
        tt          = '0;
        pred        = '0;

        if (in_valid && !phase_q) begin
            r0_d    = in;
            phase_d = 1'b1;
        end else if (in_valid) begin
            phase_d = 1'b0;
            for (int t = 0; t < NUM_STATES; t++) begin
                tt        = state_t'(t);
                pred      = {tt[0], acs_dec[t]};
                pm_d[t]   = acs_pm[t] - pm_min;
                hist_d[t] = {hist_q[pred][TB_DEPTH-2:0], tt[1]};
            end
            emit_d = (fsm_q == RUN);
            if (fsm_q == FILL) begin
                sym_cnt_d = sym_cnt_q + 1'b1;
                if (sym_cnt_d == FILL_LAST) fsm_d = RUN;
            end
        end

        if (emit_q) begin
            out_d       = hist_q[best][TB_DEPTH-1];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q     <= 1'b0;
            r0_q        <= 1'b0;
            sym_cnt_q   <= '0;
            fsm_q       <= FILL;
            emit_q      <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int t = 0; t < NUM_STATES; t++) begin
                pm_q[t]   <= (t == 0) ? '0 : PM_MAX;
                hist_q[t] <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            r0_q        <= r0_d;
            sym_cnt_q   <= sym_cnt_d;
            fsm_q       <= fsm_d;
            emit_q      <= emit_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            pm_q        <= pm_d;
            hist_q      <= hist_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef VDEC_ERRCNT_EN
    // The per-symbol normalization amount accumulates to the ML path's Hamming distance.
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin : p_err
        logic [ERR_W:0] sum;
        sum       = {1'b0, err_cnt_q} + (ERR_W + 1)'(pm_min);
        err_cnt_d = err_cnt_q;
        if (in_valid && phase_q) err_cnt_d = sum[ERR_W] ? ERR_MAX : sum[ERR_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
